// File: rtl/peripheral_master_wb.sv
// Wishbone burst master: turns an (adr, len, sel, we) command into classic or incrementing-burst beats.
// ack > err > rty per beat, bounded retries, stall timeout, one-cycle done/err completion.
module peripheral_master_wb #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [3:0]      cmd_len,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic [DW-1:0]   wr_dat,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic [DW-1:0]   rd_dat,
  output logic            rd_valid,
  output logic            done,
  output logic            err,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);

  localparam int SW = DW / 8;
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] ADR_INC   = AW'(SW);
  localparam logic [RW-1:0] RTY_LIMIT = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUS        = 2'd1,
    RETRY_WAIT = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            we_q;
  logic [AW-1:0]   adr_q;
  logic [3:0]      rem_q;
  logic            burst_q;
  logic [DW/8-1:0] sel_q;
  logic [RW-1:0]   rty_cnt_q;
  logic [TW-1:0]   to_cnt_q;
  logic            err_q;
  logic            rdy_en_q;
  logic [DW-1:0]   rd_dat_q;
  logic            rd_valid_q;
  logic            set_err;

  logic in_bus, cmd_fire, beat_ack, beat_err, beat_rty, stall;

  // Write beats only strobe once the producer has data; the cycle stays open meanwhile.
  assign in_bus   = (state_q == BUS);
  assign wb_stb_o = in_bus & (~we_q | wr_valid);
  assign beat_ack = wb_stb_o & wb_ack_i;
  assign beat_err = wb_stb_o & wb_err_i & ~wb_ack_i;
  assign beat_rty = wb_stb_o & wb_rty_i & ~wb_ack_i & ~wb_err_i;
  assign stall    = in_bus & ~(beat_ack | beat_err | beat_rty);
  assign cmd_fire = cmd_valid & cmd_ready;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    set_err   = 1'b0;
    cmd_ready = (state_q == IDLE) & rdy_en_q;
    wb_cyc_o  = in_bus;
    wb_cti_o  = 3'b000;
    wb_bte_o  = 2'b00;
    done      = (state_q == DONE);
    err       = (state_q == DONE) & err_q;
    wr_ready  = beat_ack & we_q;
    if (in_bus && burst_q) begin
      wb_cti_o = (rem_q == 4'd0) ? 3'b111 : 3'b010;
    end
    case (state_q)
      IDLE: begin
        if (cmd_fire) state_d = BUS;
      end
      BUS: begin
        if (beat_ack) begin
          if (rem_q == 4'd0) state_d = DONE;
        end else if (beat_err) begin
          state_d = DONE;
          set_err = 1'b1;
        end else if (beat_rty) begin
          if (rty_cnt_q == RTY_LIMIT) begin
            state_d = DONE;
            set_err = 1'b1;
          end else begin
            state_d = RETRY_WAIT;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d = DONE;
          set_err = 1'b1;
        end
      end
      RETRY_WAIT: state_d = BUS;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      we_q       <= 1'b0;
      adr_q      <= '0;
      rem_q      <= '0;
      burst_q    <= 1'b0;
      sel_q      <= '0;
      rty_cnt_q  <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      rdy_en_q   <= 1'b0;
      rd_dat_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rdy_en_q   <= 1'b1;
      rd_valid_q <= beat_ack & ~we_q;
      if (beat_ack && !we_q) rd_dat_q <= wb_dat_i;
      if (in_bus) err_q <= set_err;
      if (cmd_fire) begin
        we_q      <= cmd_we;
        adr_q     <= cmd_adr;
        rem_q     <= cmd_len;
        burst_q   <= (cmd_len != 4'd0);
        sel_q     <= cmd_sel;
        rty_cnt_q <= '0;
        to_cnt_q  <= '0;
      end else if (beat_ack) begin
        adr_q     <= adr_q + ADR_INC;
        rem_q     <= rem_q - 4'd1;
        rty_cnt_q <= '0;
        to_cnt_q  <= '0;
      end else if (beat_rty) begin
        rty_cnt_q <= rty_cnt_q + RW'(1);
        to_cnt_q  <= '0;
      end else if (beat_err) begin
        to_cnt_q  <= '0;
      end else if (stall) begin
        to_cnt_q  <= to_cnt_q + TW'(1);
      end
    end
  end

  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_dat_o = wr_dat;
  assign rd_dat   = rd_dat_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_peripheral_master_wb.sv
// Directed bench for peripheral_master_wb: scripted slave, write producer and event monitor in one stepping task.
module tb_peripheral_master_wb;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_len;
  logic [3:0]  cmd_sel;
  logic [31:0] wr_dat;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_dat;
  logic        rd_valid, done, err;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  peripheral_master_wb dut (
    .wb_clk_i (wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr  (cmd_adr),   .cmd_len  (cmd_len),   .cmd_sel(cmd_sel),
    .wr_dat   (wr_dat),    .wr_valid (wr_valid),  .wr_ready(wr_ready),
    .rd_dat   (rd_dat),    .rd_valid (rd_valid),  .done(done), .err(err),
    .wb_adr_o (wb_adr_o),  .wb_dat_o (wb_dat_o),  .wb_sel_o(wb_sel_o),
    .wb_we_o  (wb_we_o),   .wb_cyc_o (wb_cyc_o),  .wb_stb_o(wb_stb_o),
    .wb_cti_o (wb_cti_o),  .wb_bte_o (wb_bte_o),  .wb_dat_i(wb_dat_i),
    .wb_ack_i (wb_ack_i),  .wb_err_i (wb_err_i),  .wb_rty_i(wb_rty_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_cmp = 0;
  int n_mis = 0;

  // scenario knobs
  int          ack_delay, rty_beat, rty_left, err_beat, n_wr, gap_beat, gap_left;
  bit          slv_mute, cmd_pend;
  logic [31:0] rd_mem [16];
  logic [31:0] wr_mem [16];
  // observations
  int          beat, slv_wait, wr_cnt, done_cnt, cyc_rise, cyc_gap, stb_low, stb_cyc, rdy_bad;
  bit          err_seen, seen_c, cyc_prev;
  logic [31:0] rd_q[$], ack_adr[$], ack_dat[$], rty_adr[$];
  logic [2:0]  ack_cti[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs after posedge, slave responds at negedge, monitor samples just after.
  task automatic step();
    @(posedge wb_clk_i); #1;
    cmd_valid = cmd_pend;
    if (wr_cnt < n_wr && !(wr_cnt == gap_beat && gap_left > 0)) begin
      wr_valid = 1'b1;
      wr_dat   = wr_mem[wr_cnt];
    end else begin
      wr_valid = 1'b0;
      if (wr_cnt == gap_beat && gap_left > 0) gap_left--;
    end
    @(negedge wb_clk_i);
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    if (wb_stb_o) begin
      if (wb_adr_o[3:0] == 4'hC) seen_c = 1'b1;
      if (!slv_mute) begin
        if (slv_wait < ack_delay) slv_wait++;
        else begin
          slv_wait = 0;
          if (beat == rty_beat && rty_left > 0) begin
            wb_rty_i = 1'b1; rty_left--; rty_adr.push_back(wb_adr_o);
          end else if (beat == err_beat) begin
            wb_err_i = 1'b1;
          end else begin
            wb_ack_i = 1'b1;
            wb_dat_i = rd_mem[beat];
            ack_adr.push_back(wb_adr_o);
            ack_cti.push_back(wb_cti_o);
            ack_dat.push_back(wb_dat_o);
            beat++;
          end
        end
      end
    end
    #2;
    if (wb_cyc_o && !cyc_prev) cyc_rise++;
    if (!wb_cyc_o && cyc_rise > 0 && !done && done_cnt == 0) cyc_gap++;
    cyc_prev = wb_cyc_o;
    if (wb_cyc_o && !wb_stb_o) stb_low++;
    if (wb_stb_o) stb_cyc++;
    if (cmd_ready && (wb_cyc_o || done)) rdy_bad++;
    if (wr_ready) wr_cnt++;
    if (rd_valid) rd_q.push_back(rd_dat);
    if (done) begin done_cnt++; err_seen = err; end
    if (cmd_valid && cmd_ready) cmd_pend = 1'b0;
  endtask

  task automatic clear();
    beat = 0; slv_wait = 0; wr_cnt = 0; done_cnt = 0; cyc_rise = 0; cyc_gap = 0;
    stb_low = 0; stb_cyc = 0; rdy_bad = 0; err_seen = 0; seen_c = 0;
    rd_q.delete(); ack_adr.delete(); ack_dat.delete(); rty_adr.delete(); ack_cti.delete();
  endtask

  task automatic run(input logic we, input logic [31:0] adr, input logic [3:0] len, input int budget);
    int n;
    clear();
    cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_sel = 4'hF; cmd_pend = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    step(); step();
    check("done_once", done_cnt, 1);
  endtask

  task automatic defaults();
    ack_delay = 0; rty_beat = 0; rty_left = 0; err_beat = 99;
    n_wr = 0; gap_beat = 99; gap_left = 0; slv_mute = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_ni = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_sel = '0;
    wr_dat = '0; wr_valid = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    cmd_pend = 1'b0; cyc_prev = 1'b0;
    defaults(); clear();
    for (int i = 0; i < 16; i++) begin rd_mem[i] = '0; wr_mem[i] = '0; end

    // reset state
    repeat (3) step();
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_cti_bte", {wb_cti_o, wb_bte_o}, 0);
    #1 wb_rst_ni = 1'b1;
    #1 check("rdy_before_edge", cmd_ready, 0);
    step();
    check("rdy_after_edge", cmd_ready, 1);

    // single read with 2 wait cycles
    defaults(); ack_delay = 2; rd_mem[0] = 32'hDEADBEEF;
    run(1'b0, 32'h100, 4'd0, 50);
    check("sr_err", err_seen, 0);
    check("sr_rd_cnt", rd_q.size(), 1);
    check("sr_rd_dat", rd_q[0], 32'hDEADBEEF);
    check("sr_adr", ack_adr[0], 32'h100);
    check("sr_cti", ack_cti[0], 3'b000);

    // zero-wait write burst
    defaults(); n_wr = 4;
    for (int i = 0; i < 4; i++) wr_mem[i] = 32'(i + 1);
    run(1'b1, 32'h200, 4'd3, 50);
    check("wb_err", err_seen, 0);
    check("wb_wr_ready_cnt", wr_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wb_adr%0d", i), ack_adr[i], 32'h200 + 32'(4 * i));
      check($sformatf("wb_dat%0d", i), ack_dat[i], 32'(i + 1));
      check($sformatf("wb_cti%0d", i), ack_cti[i], (i == 3) ? 3'b111 : 3'b010);
    end
    check("wb_rdy_busy", rdy_bad, 0);

    // write burst with producer gap before beat 2
    defaults(); n_wr = 4; gap_beat = 2; gap_left = 3;
    for (int i = 0; i < 4; i++) wr_mem[i] = 32'hA0 + 32'(i);
    run(1'b1, 32'h200, 4'd3, 60);
    check("gap_stb_low", stb_low, 3);
    check("gap_cyc_rise", cyc_rise, 1);
    check("gap_err", err_seen, 0);
    for (int i = 0; i < 4; i++) check($sformatf("gap_dat%0d", i), ack_dat[i], 32'hA0 + 32'(i));

    // two retries on beat 0, then success
    defaults(); rty_left = 2; rd_mem[0] = 32'h1111_0000; rd_mem[1] = 32'h2222_0001;
    run(1'b0, 32'h300, 4'd1, 60);
    check("rty_cyc_rise", cyc_rise, 3);
    check("rty_cyc_gap", cyc_gap, 2);
    check("rty_adr0", rty_adr[0], 32'h300);
    check("rty_adr1", rty_adr[1], 32'h300);
    check("rty_ack_adr0", ack_adr[0], 32'h300);
    check("rty_rd_cnt", rd_q.size(), 2);
    check("rty_rd1", rd_q[1], 32'h2222_0001);
    check("rty_err", err_seen, 0);

    // retries exhausted
    defaults(); rty_left = 4;
    run(1'b0, 32'h380, 4'd1, 60);
    check("rtyx_err", err_seen, 1);
    check("rtyx_cyc_rise", cyc_rise, 4);
    check("rtyx_rd_cnt", rd_q.size(), 0);

    // bus error on beat 2 of a 4-beat read
    defaults(); err_beat = 2; rd_mem[0] = 32'h11; rd_mem[1] = 32'h22; rd_mem[2] = 32'h33;
    run(1'b0, 32'h400, 4'd3, 60);
    check("berr_err", err_seen, 1);
    check("berr_rd_cnt", rd_q.size(), 2);
    check("berr_rd0", rd_q[0], 32'h11);
    check("berr_rd1", rd_q[1], 32'h22);
    check("berr_no_c", seen_c, 0);
    check("berr_cyc_gap", cyc_gap, 0);

    // silent slave: timeout after exactly 255 strobed cycles
    defaults(); slv_mute = 1'b1;
    run(1'b0, 32'h500, 4'd0, 400);
    check("to_err", err_seen, 1);
    check("to_stb_cycles", stb_cyc, 255);

    // reset in the middle of a burst
    defaults(); slv_mute = 1'b1; clear();
    cmd_we = 1'b0; cmd_adr = 32'h600; cmd_len = 4'd3; cmd_sel = 4'hF; cmd_pend = 1'b1;
    repeat (6) step();
    check("mid_cyc_before", wb_cyc_o, 1);
    #1 wb_rst_ni = 1'b0;
    #1;
    check("mid_cyc_now", wb_cyc_o, 0);
    check("mid_stb_now", wb_stb_o, 0);
    slv_mute = 1'b0;
    repeat (2) step();
    #1 wb_rst_ni = 1'b1;
    repeat (4) step();
    check("mid_no_done", done_cnt, 0);
    check("mid_rdy_back", cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
